// File: rtl/rob_ctrl_pkg.sv
// Shared ROB types and constants used by the rob_ctrl slice.
package rob_ctrl_pkg;

  localparam int unsigned ROB_DEPTH  = 64;
  localparam int unsigned ROB_ADDR_W = $clog2(ROB_DEPTH);
  localparam int unsigned ROB_WIDTH  = 2;

  typedef logic [ROB_ADDR_W-1:0] rob_id_t;

  typedef enum logic [1:0] {
    ROB_RUN,
    ROB_FLUSH,
    ROB_WAIT_ACK
  } rob_state_e;

  function automatic logic [1:0] popcnt2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/rob_status_vec.sv
// Per-entry valid/done/exception bits with two alloc, two writeback and two
// retire-clear ports plus a synchronous bulk clear.
module rob_status_vec
  import rob_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH  = ROB_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic [1:0]            alloc_i,
  input  logic [2*ADDR_W-1:0]   alloc_id_i,
  input  logic [1:0]            wb_i,
  input  logic [2*ADDR_W-1:0]   wb_id_i,
  input  logic [1:0]            wb_exc_i,
  input  logic [1:0]            ret_i,
  input  logic [2*ADDR_W-1:0]   ret_id_i,
  output logic [DEPTH-1:0]      valid_o,
  output logic [DEPTH-1:0]      done_o,
  output logic [DEPTH-1:0]      exc_o
);

  logic [DEPTH-1:0] valid_q, done_q, exc_q;

  // Later assignments win: writeback, then retire clear, then allocation.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      valid_q <= '0;
      done_q  <= '0;
      exc_q   <= '0;
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        if (wb_i[p] && valid_q[wb_id_i[p*ADDR_W +: ADDR_W]]) begin
          done_q[wb_id_i[p*ADDR_W +: ADDR_W]] <= 1'b1;
          if (wb_exc_i[p]) exc_q[wb_id_i[p*ADDR_W +: ADDR_W]] <= 1'b1;
        end
      end
      for (int unsigned p = 0; p < 2; p++) begin
        if (ret_i[p]) valid_q[ret_id_i[p*ADDR_W +: ADDR_W]] <= 1'b0;
      end
      for (int unsigned p = 0; p < 2; p++) begin
        if (alloc_i[p]) begin
          valid_q[alloc_id_i[p*ADDR_W +: ADDR_W]] <= 1'b1;
          done_q[alloc_id_i[p*ADDR_W +: ADDR_W]]  <= 1'b0;
          exc_q[alloc_id_i[p*ADDR_W +: ADDR_W]]   <= 1'b0;
        end
      end
    end
  end

  assign valid_o = valid_q;
  assign done_o  = done_q;
  assign exc_o   = exc_q;

endmodule

// File: rtl/rob_ctrl.sv
// ROB allocation/retire scheduler: 2-wide alloc, 2 writeback ports, in-order
// 2-wide retire, and flush sequencing on head exception or external request.
module rob_ctrl
  import rob_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH  = ROB_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          alloc_req_i,
  output logic                alloc_ready_o,
  output logic [2*ADDR_W-1:0] alloc_id_o,
  input  logic [1:0]          wb_valid_i,
  input  logic [2*ADDR_W-1:0] wb_id_i,
  input  logic [1:0]          wb_exc_i,
  output logic [1:0]          retire_o,
  output logic [2*ADDR_W-1:0] retire_id_o,
  output logic                retire_exc_o,
  input  logic                flush_req_i,
  output logic                flush_o,
  input  logic                flush_ack_i,
  output logic [ADDR_W:0]     rob_cnt_o
);

  localparam logic [ADDR_W-1:0] ID_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_HI = (ADDR_W+1)'(DEPTH - 2);

  rob_state_e        state_q, state_d;
  logic [ADDR_W-1:0] head_q, head_d, tail_q, tail_d, head1, id1;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [DEPTH-1:0]  valid, done, exc;
  logic [1:0]        fire, ret;
  logic              ret_exc, clr;

  assign fire  = alloc_req_i & {2{ready_q}};
  assign id1   = tail_q + {{(ADDR_W-1){1'b0}}, alloc_req_i[0]};
  assign head1 = head_q + ID_ONE;

  rob_status_vec #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_status (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .alloc_i    (fire),
    .alloc_id_i ({id1, tail_q}),
    .wb_i       (wb_valid_i),
    .wb_id_i    (wb_id_i),
    .wb_exc_i   (wb_exc_i),
    .ret_i      (ret),
    .ret_id_i   ({head1, head_q}),
    .valid_o    (valid),
    .done_o     (done),
    .exc_o      (exc)
  );

  // An excepting head retires alone in slot 0.
  always_comb begin
    ret     = '0;
    ret_exc = 1'b0;
    if (state_q == ROB_RUN && valid[head_q] && done[head_q]) begin
      ret[0]  = 1'b1;
      ret_exc = exc[head_q];
      if (!exc[head_q] && valid[head1] && done[head1] && !exc[head1])
        ret[1] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ROB_RUN:      if (flush_req_i || ret_exc) state_d = ROB_FLUSH;
      ROB_FLUSH:    state_d = ROB_WAIT_ACK;
      ROB_WAIT_ACK: if (flush_ack_i) state_d = ROB_RUN;
      default:      state_d = ROB_RUN;
    endcase

    // Clearing on entry to FLUSH makes the flush cycle itself observe an empty ROB.
    clr    = (state_d == ROB_FLUSH);
    cnt_d  = cnt_q + {{(ADDR_W-1){1'b0}}, popcnt2(fire)}
                   - {{(ADDR_W-1){1'b0}}, popcnt2(ret)};
    head_d = head_q + {{(ADDR_W-2){1'b0}}, popcnt2(ret)};
    tail_d = tail_q + {{(ADDR_W-2){1'b0}}, popcnt2(fire)};
    if (clr) begin
      cnt_d  = '0;
      head_d = '0;
      tail_d = '0;
    end
    ready_d = (cnt_d <= CNT_HI) && (state_d == ROB_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ROB_RUN;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign alloc_ready_o = ready_q;
  assign alloc_id_o    = {id1, tail_q};
  assign retire_o      = ret;
  assign retire_id_o   = {ret[1] ? head1 : '0, ret[0] ? head_q : '0};
  assign retire_exc_o  = ret_exc;
  assign flush_o       = (state_q != ROB_RUN);
  assign rob_cnt_o     = cnt_q;

endmodule
